bsg_dbi_decode: RTL and testbench
=================================

BSG_DBI_DECODE -- requirements
Module: bsg_dbi_decode

Interface
REQ-001 Parameter width_p, default 16, data width in bits; SHALL be a multiple of 8, minimum 8.
REQ-002 Derived lanes_lp = width_p/8, one DBI flag per byte lane.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n_i  input  1  reset, synchronous and active-low.
REQ-005 v_i  input  1  upstream valid.
REQ-006 data_i  input  width_p  encoded data, possibly lane-inverted.
REQ-007 dbi_i  input  lanes_lp  bit k=1 means lane k (data_i[8k+7:8k]) arrives inverted.
REQ-008 ready_o  output  1  block can accept an item this cycle.
REQ-009 v_o  output  1  decoded item available at data_o.
REQ-010 data_o  output  width_p  decoded data, head item.
REQ-011 yumi_i  input  1  downstream consumes the head item this cycle.
REQ-012 clear_count_i  input  1  synchronous clear of inv_count_o.
REQ-013 inv_count_o  output  16  saturating count of inverted lanes accepted.

Function
REQ-014 Decode: lane k of stored item SHALL equal ~data_i lane k when dbi_i[k]=1, else data_i lane k unchanged.
REQ-015 Decoding SHALL occur on enqueue; stored entries hold decoded data only.
REQ-016 Storage SHALL be a 2-entry FIFO with registered occupancy count 0..2.
REQ-017 Enqueue SHALL occur iff v_i & ready_o at a rising edge; v_i while ready_o=0 is ignored, no state change.
REQ-018 ready_o SHALL be 1 iff occupancy < 2 and reset_n_i was high at the last edge; no combinational path from yumi_i to ready_o.
REQ-019 v_o SHALL be 1 iff occupancy > 0; data_o SHALL be the oldest entry.
REQ-020 Dequeue SHALL occur iff yumi_i & v_o; yumi_i with v_o=0 SHALL be ignored (bench treats as protocol violation, DUT unaffected).
REQ-021 Latency: item accepted at edge N SHALL appear on data_o with v_o=1 after edge N when FIFO was empty (1 cycle).
REQ-022 Simultaneous enqueue and dequeue at occupancy 1: occupancy stays 1, new item becomes head next cycle.
REQ-023 Occupancy 2: ready_o=0; a dequeue frees one slot, ready_o=1 next cycle.
REQ-024 Order SHALL be strictly FIFO; no item dropped or duplicated.
REQ-025 data_o SHALL be 0 when v_o=0 after reset; after drain it holds the last-dequeued slot contents (don't-care to bench).
REQ-026 On each enqueue inv_count_o SHALL add popcount(dbi_i), saturating at 16'hFFFF, no wrap.
REQ-027 clear_count_i=1 SHALL set inv_count_o to 0 at the edge, taking priority over a same-cycle increment (that cycle's lanes not counted).
REQ-028 Outputs SHALL be driven from registers only, except data_o via head-pointer mux of registered entries.

Reset
REQ-029 With reset_n_i=0 at an edge: occupancy 0, pointers 0, entries 0, inv_count_o 0.
REQ-030 During reset and first cycle in reset: v_o=0, ready_o=0, data_o=0; ready_o=1 on the cycle after the first edge with reset_n_i=1.
REQ-031 Reset mid-operation SHALL discard all stored items; handshakes during reset are ignored.

Verification
REQ-032 width_p=16, data_i=16'h00FF, dbi_i=2'b01, v_i=1 into empty FIFO -> next cycle v_o=1, data_o=16'h0000, inv_count_o=1.
REQ-033 Enqueue 16'h1234/dbi 2'b00 then 16'hEDCB/dbi 2'b11, yumi_i=0 -> ready_o=0 after second edge; then yumi twice -> data_o 16'h1234 then 16'h1234, inv_count_o=2.
REQ-034 Occupancy 1, v_i=1 and yumi_i=1 same cycle -> occupancy stays 1, v_o=1, ready_o=1, next head is new item.
REQ-035 Preload inv_count_o=16'hFFFE, enqueue dbi_i=2'b11 -> inv_count_o=16'hFFFF, stays there on further inverted enqueues.
REQ-036 clear_count_i=1 with enqueue dbi_i=2'b11 at count 5 -> inv_count_o=0.
REQ-037 Occupancy 2, reset_n_i=0 one edge -> v_o=0, ready_o=0, inv_count_o=0; after release, ready_o=1 and no stale item appears.

Source files
------------

// File: rtl/bsg_dbi_decode.sv
// Data-bus-inversion decoder: undoes per-byte-lane inversion on enqueue into a
// 2-entry FIFO and keeps a saturating count of the inverted lanes it accepted.
module bsg_dbi_decode #(
  parameter int width_p  = 16,
  localparam int lanes_lp = width_p / 8
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                v_i,
  input  logic [width_p-1:0]  data_i,
  input  logic [lanes_lp-1:0] dbi_i,
  output logic                ready_o,
  output logic                v_o,
  output logic [width_p-1:0]  data_o,
  input  logic                yumi_i,
  input  logic                clear_count_i,
  output logic [15:0]         inv_count_o
);

  // Handshakes: an item is accepted at a rising edge iff v_i & ready_o, and the
  // head item is consumed at a rising edge iff yumi_i & v_o. ready_o comes from
  // a register, so it never depends combinationally on yumi_i.

  logic [width_p-1:0] r_mem [2];
  logic               r_wptr;
  logic               r_rptr;
  logic [1:0]         r_count;
  logic               r_ready;
  logic [15:0]        r_inv_count;

  logic [width_p-1:0] w_decoded;
  logic [15:0]        w_pop;
  logic [16:0]        w_sum;
  logic               w_enq;
  logic               w_deq;
  logic [1:0]         w_count_next;

  always_comb begin
    w_decoded = data_i;
    w_pop     = 16'd0;
    for (int k = 0; k < lanes_lp; k++) begin
      if (dbi_i[k]) w_decoded[8*k +: 8] = ~data_i[8*k +: 8];
      w_pop = w_pop + 16'(dbi_i[k]);
    end
  end

  assign w_enq        = v_i & r_ready;
  assign w_deq        = yumi_i & (r_count != 2'd0);
  assign w_count_next = r_count + {1'b0, w_enq} - {1'b0, w_deq};
  assign w_sum        = {1'b0, r_inv_count} + {1'b0, w_pop};

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_mem[0]    <= '0;
      r_mem[1]    <= '0;
      r_wptr      <= 1'b0;
      r_rptr      <= 1'b0;
      r_count     <= 2'd0;
      r_ready     <= 1'b0;
      r_inv_count <= 16'd0;
    end else begin
      if (w_enq) begin
        r_mem[r_wptr] <= w_decoded;
        r_wptr        <= ~r_wptr;
      end
      if (w_deq) r_rptr <= ~r_rptr;
      r_count <= w_count_next;
      r_ready <= (w_count_next != 2'd2);
      // Clear wins over a same-cycle increment; the sum saturates instead of wrapping.
      if (clear_count_i)
        r_inv_count <= 16'd0;
      else if (w_enq)
        r_inv_count <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
    end
  end

  assign ready_o     = r_ready;
  assign v_o         = (r_count != 2'd0);
  assign data_o      = r_mem[r_rptr];
  assign inv_count_o = r_inv_count;

endmodule

// File: tb/tb_bsg_dbi_decode.sv
// Self-checking bench for bsg_dbi_decode: a behavioural model with an expected
// queue is compared against the DUT outputs every cycle.
module tb_bsg_dbi_decode;
  localparam int W = 16;
  localparam int L = W / 8;

  logic         clk_i = 1'b0;
  logic         reset_n_i = 1'b0;
  logic         v_i = 1'b0;
  logic [W-1:0] data_i = '0;
  logic [L-1:0] dbi_i = '0;
  logic         ready_o;
  logic         v_o;
  logic [W-1:0] data_o;
  logic         yumi_i = 1'b0;
  logic         clear_count_i = 1'b0;
  logic [15:0]  inv_count_o;

  bsg_dbi_decode #(.width_p(W)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .data_i(data_i),
    .dbi_i(dbi_i), .ready_o(ready_o), .v_o(v_o), .data_o(data_o),
    .yumi_i(yumi_i), .clear_count_i(clear_count_i), .inv_count_o(inv_count_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] decode(input logic [W-1:0] d, input logic [L-1:0] f);
    logic [W-1:0] r;
    r = d;
    for (int k = 0; k < L; k++) if (f[k]) r[8*k +: 8] = d[8*k +: 8] ^ 8'hFF;
    return r;
  endfunction

  // scoreboard / reference model
  logic [W-1:0] exp_q[$];
  logic [15:0]  exp_cnt = 16'd0;
  logic         m_ready = 1'b0;
  logic         m_fresh = 1'b1;
  logic         mon_en = 1'b0;

  always @(negedge clk_i) begin
    if (mon_en) begin
      int unsigned s;
      check("v_o", 32'(v_o), 32'(exp_q.size() > 0));
      check("ready_o", 32'(ready_o), 32'(m_ready));
      check("inv_count_o", 32'(inv_count_o), 32'(exp_cnt));
      if (exp_q.size() > 0) check("data_o", 32'(data_o), 32'(exp_q[0]));
      else if (m_fresh)     check("data_o_reset", 32'(data_o), 32'd0);

      if (!reset_n_i) begin
        exp_q.delete();
        exp_cnt = 16'd0;
        m_ready = 1'b0;
        m_fresh = 1'b1;
      end else begin
        logic enq;
        enq = v_i && m_ready;
        if (yumi_i && exp_q.size() > 0) void'(exp_q.pop_front());
        if (enq) begin
          exp_q.push_back(decode(data_i, dbi_i));
          m_fresh = 1'b0;
        end
        if (clear_count_i) exp_cnt = 16'd0;
        else if (enq) begin
          s = 32'(exp_cnt) + 32'($countones(dbi_i));
          exp_cnt = (s > 32'hFFFF) ? 16'hFFFF : s[15:0];
        end
        m_ready = (exp_q.size() < 2);
      end
    end
  end

  // driver: applies inputs for one clock period
  task automatic drive(input logic v, input logic [W-1:0] d, input logic [L-1:0] f,
                       input logic y, input logic clr, input logic rst_n = 1'b1);
    v_i = v; data_i = d; dbi_i = f; yumi_i = y; clear_count_i = clr; reset_n_i = rst_n;
    @(posedge clk_i); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n_i = 1'b0;
    @(posedge clk_i); #1;
    mon_en = 1'b1;
    drive(1'b1, 16'hAAAA, 2'b11, 1'b1, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    idle(2);

    // single inverted lane into empty FIFO
    drive(1'b1, 16'h00FF, 2'b01, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    idle(1);

    // fill to two entries, then drain
    drive(1'b1, 16'h1234, 2'b00, 1'b0, 1'b0);
    drive(1'b1, 16'hEDCB, 2'b11, 1'b0, 1'b0);
    drive(1'b1, 16'hFFFF, 2'b11, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    idle(1);

    // simultaneous enqueue and dequeue at occupancy 1
    drive(1'b1, 16'h5A5A, 2'b10, 1'b0, 1'b0);
    drive(1'b1, 16'hC3C3, 2'b01, 1'b1, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    idle(1);

    // count to 5, then clear colliding with an inverted enqueue
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    drive(1'b1, 16'h0102, 2'b11, 1'b0, 1'b0);
    drive(1'b1, 16'h0304, 2'b11, 1'b1, 1'b0);
    drive(1'b1, 16'h0506, 2'b01, 1'b1, 1'b0);
    drive(1'b1, 16'h0708, 2'b11, 1'b1, 1'b1);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    idle(1);

    // yumi with nothing valid must not disturb anything
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    idle(1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), W'($urandom_range(0, 65535)), L'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)) & v_o, ($urandom_range(0, 19) == 0));
    end
    idle(3);

    // reset while full
    drive(1'b1, 16'h1111, 2'b01, 1'b0, 1'b0);
    drive(1'b1, 16'h2222, 2'b10, 1'b0, 1'b0);
    drive(1'b1, 16'h3333, 2'b11, 1'b1, 1'b0, 1'b0);
    idle(3);
    drive(1'b1, 16'h4444, 2'b00, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    idle(1);

    // drive the count up to saturation with back-to-back traffic
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 32772; i++)
      drive(1'b1, W'($urandom_range(0, 65535)), 2'b11, v_o, 1'b0);
    drive(1'b0, '0, '0, v_o, 1'b0);
    check("saturated_count", 32'(inv_count_o), 32'h0000FFFF);
    idle(3);
    check("drained_queue", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
